// File: rtl/wddl_mod_reduce_stage.sv
// Conditional subtract-Q stage for the WDDL dual-rail adder sum, sequenced as precharge, capture, reduce, present.
// The result appears PRECHARGE_CYCLES+3 cycles after in_valid is seen in IDLE, and it is held in OUT until out_ready.
module wddl_mod_reduce_stage #(
  parameter int WIDTH            = 13,
  parameter int Q                = 3329,
  parameter int PRECHARGE_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH:0]   sum_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_n,
  output logic             err_rail,
  output logic             err_range,
  output logic             busy
);
  localparam int               CW       = (PRECHARGE_CYCLES > 1) ? $clog2(PRECHARGE_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(PRECHARGE_CYCLES - 1);
  localparam logic [WIDTH:0]   Q_EXT    = (WIDTH+1)'(Q);
  localparam logic [WIDTH+1:0] TWO_Q    = (WIDTH+2)'(2 * Q);
  localparam logic [WIDTH-1:0] Q_LOW    = WIDTH'(Q);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_EVAL, S_RED, S_OUT} state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   cap_q, cap_d, cap_n_q, cap_n_d;
  logic [WIDTH-1:0] res_q, res_d, res_n_q, res_n_d;
  logic             err_rail_q, err_rail_d, err_range_q, err_range_d;
  logic [WIDTH-1:0] red_r;

  // Low WIDTH bits of the signed difference cap-Q; a negative difference keeps cap unchanged.
  always_comb begin
    red_r = (cap_q < Q_EXT) ? cap_q[WIDTH-1:0] : cap_q[WIDTH-1:0] - Q_LOW;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_d       = cap_q;
    cap_n_d     = cap_n_q;
    res_d       = res_q;
    res_n_d     = res_n_q;
    err_rail_d  = err_rail_q;
    err_range_d = err_range_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_PRE;
          cnt_d   = CNT_LOAD;
        end
      end
      S_PRE: begin
        cap_d       = '0;
        cap_n_d     = '0;
        res_d       = '0;
        res_n_d     = '0;
        err_rail_d  = 1'b0;
        err_range_d = 1'b0;
        if (!in_valid) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_EVAL;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_EVAL: begin
        cap_d   = sum;
        cap_n_d = sum_n;
        state_d = S_RED;
      end
      S_RED: begin
        // Rail check uses the captured pair, so it reflects exactly what was sampled.
        res_d       = red_r;
        res_n_d     = ~red_r;
        err_rail_d  = |(~(cap_q ^ cap_n_q));
        err_range_d = ({1'b0, cap_q} >= TWO_Q);
        state_d     = S_OUT;
      end
      S_OUT: begin
        if (out_ready) begin
          res_d       = '0;
          res_n_d     = '0;
          err_rail_d  = 1'b0;
          err_range_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cap_q       <= '0;
      cap_n_q     <= '0;
      res_q       <= '0;
      res_n_q     <= '0;
      err_rail_q  <= 1'b0;
      err_range_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_q       <= cap_d;
      cap_n_q     <= cap_n_d;
      res_q       <= res_d;
      res_n_q     <= res_n_d;
      err_rail_q  <= err_rail_d;
      err_range_q <= err_range_d;
    end
  end

  assign in_ready  = (state_q == S_EVAL);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign res       = res_q;
  assign res_n     = res_n_q;
  assign err_rail  = err_rail_q;
  assign err_range = err_range_q;
endmodule

// File: tb/tb_wddl_mod_reduce_stage.sv
// Bench for wddl_mod_reduce_stage: a scoreboard-checked P=1 instance under random traffic and backpressure,
// plus a P=3 instance used for latency and precharge-abort cases.
`timescale 1ns/1ps
module tb_wddl_mod_reduce_stage;
  localparam int W  = 13;
  localparam int QM = 3329;
  localparam int P  = 1;
  localparam int P3 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_b, in_valid, in_ready, out_valid, out_ready, err_rail, err_range, busy;
  logic [W:0]   sum, sum_n;
  logic [W-1:0] res, res_n;

  logic         b_rst_b, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_err_rail, b_err_range, b_busy;
  logic [W:0]   b_sum, b_sum_n;
  logic [W-1:0] b_res, b_res_n;

  wddl_mod_reduce_stage #(.WIDTH(W), .Q(QM), .PRECHARGE_CYCLES(P)) dut (
    .clk(clk), .rst_b(rst_b), .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .sum_n(sum_n),
    .out_valid(out_valid), .out_ready(out_ready), .res(res), .res_n(res_n),
    .err_rail(err_rail), .err_range(err_range), .busy(busy));

  wddl_mod_reduce_stage #(.WIDTH(W), .Q(QM), .PRECHARGE_CYCLES(P3)) dut3 (
    .clk(clk), .rst_b(b_rst_b), .in_valid(b_in_valid), .in_ready(b_in_ready), .sum(b_sum), .sum_n(b_sum_n),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .res(b_res), .res_n(b_res_n),
    .err_rail(b_err_rail), .err_range(b_err_range), .busy(b_busy));

  typedef struct packed {
    logic [W-1:0] res;
    logic         er;
    logic         eg;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   stall_left = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT at %0t", nm, $time);
  endtask

  // Reference: modular reduction by plain integer arithmetic on the true rail.
  function automatic exp_t model(input int s, input int sn);
    exp_t e;
    int   r;
    r    = (s < QM) ? s : (s - QM) % (1 << W);
    e.res = W'(r);
    e.eg  = (s >= 2 * QM);
    e.er  = 1'b0;
    for (int i = 0; i <= W; i++)
      if (((s >> i) & 1) == ((sn >> i) & 1)) e.er = 1'b1;
    return e;
  endfunction

  // Must be entered just after a negedge.
  task automatic send(input int s, input int sn);
    int n;
    bit seen_rdy;
    sum      = (W+1)'(s);
    sum_n    = (W+1)'(sn);
    in_valid = 1'b1;
    sb.push_back(model(s, sn));
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      timeout("idle_wait");
      in_valid = 1'b0;
      return;
    end
    n        = 0;
    seen_rdy = 1'b0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (in_ready) begin
        chk("in_ready_cycle", 32'(n), 32'(P + 1));
        in_valid = 1'b0;
        seen_rdy = 1'b1;
      end
    end
    if (!out_valid) timeout("out_valid");
    else chk("latency", 32'(n), 32'(P + 3));
    chk("in_ready_seen", 32'(seen_rdy), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send_ok(input int s);
    send(s, s ^ 'h3FFF);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) timeout("wait_idle");
  endtask

  task automatic abort_pre();
    sum      = (W+1)'(555);
    sum_n    = ~sum;
    in_valid = 1'b1;
    @(negedge clk);
    chk("abort_in_pre", 32'(busy), 32'd1);
    chk("abort_no_rdy_pre", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    chk("abort_no_rdy_after", 32'(in_ready), 32'd0);
  endtask

  task automatic reset_mid_red();
    int n;
    sum      = (W+1)'(4321);
    sum_n    = ~sum;
    in_valid = 1'b1;
    n        = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) timeout("red_rdy");
    in_valid = 1'b0;
    @(negedge clk);
    chk("red_busy", 32'(busy), 32'd1);
    #2 rst_b = 1'b0;
    #1;
    chk("red_rst_busy", 32'(busy), 32'd0);
    chk("red_rst_outs", 32'({out_valid, in_ready, err_rail, err_range, res, res_n}), 32'd0);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic dut3_tests();
    int n;
    int rdy_cnt;
    int out_cnt;
    @(negedge clk);
    b_sum      = (W+1)'(7000);
    b_sum_n    = ~b_sum;
    b_in_valid = 1'b1;
    n = 0;
    while (!b_out_valid && n < 50) begin
      @(negedge clk);
      n++;
      if (b_in_ready) b_in_valid = 1'b0;
    end
    if (!b_out_valid) timeout("p3_out_valid");
    chk("p3_latency", 32'(n), 32'(P3 + 3));
    chk("p3_res", 32'(b_res), 32'd3671);
    chk("p3_err_range", 32'(b_err_range), 32'd1);
    @(negedge clk);
    chk("p3_back_idle", 32'(b_busy), 32'd0);
    // Reset asserted in the second precharge cycle.
    b_in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #2 b_rst_b = 1'b0;
    #1;
    chk("p3_rst_busy", 32'(b_busy), 32'd0);
    chk("p3_rst_outs", 32'({b_out_valid, b_in_ready, b_res, b_res_n}), 32'd0);
    b_in_valid = 1'b0;
    @(negedge clk);
    b_rst_b = 1'b1;
    out_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b_out_valid) out_cnt++;
    end
    chk("p3_rst_no_out", 32'(out_cnt), 32'd0);
    // in_valid withdrawn during precharge.
    rdy_cnt    = 0;
    b_in_valid = 1'b1;
    @(negedge clk);
    if (b_in_ready) rdy_cnt++;
    @(negedge clk);
    if (b_in_ready) rdy_cnt++;
    b_in_valid = 1'b0;
    out_cnt    = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_in_ready) rdy_cnt++;
      if (b_out_valid) out_cnt++;
    end
    chk("p3_abort_no_rdy", 32'(rdy_cnt), 32'd0);
    chk("p3_abort_no_out", 32'(out_cnt), 32'd0);
    chk("p3_abort_idle", 32'(b_busy), 32'd0);
  endtask

  // Downstream sink: random acceptance, with an optional forced stall of OUT cycles.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : monitor
    logic         pv, pacc;
    logic [W-1:0] pr, inv;
    exp_t         e;
    pv   = 1'b0;
    pacc = 1'b0;
    pr   = '0;
    forever begin
      @(negedge clk);
      if (pv && !pacc) chk("valid_hold", 32'(out_valid), 32'd1);
      if (out_valid) begin
        inv = ~res;
        chk("res_n_complement", 32'(res_n), 32'(inv));
        if (pv && !pacc) chk("res_hold", 32'(res), 32'(pr));
        if (out_ready) begin
          if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got res 0x%0h, expected no output at %0t", res, $time);
          end else begin
            e = sb.pop_front();
            chk("res", 32'(res), 32'(e.res));
            chk("err_rail", 32'(err_rail), 32'(e.er));
            chk("err_range", 32'(err_range), 32'(e.eg));
          end
        end
      end else begin
        chk("precharge_res", 32'({res, res_n}), 32'd0);
        chk("idle_flags", 32'({err_rail, err_range}), 32'd0);
      end
      pv   = out_valid;
      pacc = out_ready;
      pr   = res;
    end
  end

  initial begin
    int s, sn, n;
    rst_b      = 1'b0;
    in_valid   = 1'b0;
    sum        = '0;
    sum_n      = '0;
    b_rst_b    = 1'b0;
    b_in_valid = 1'b0;
    b_out_ready = 1'b1;
    b_sum      = '0;
    b_sum_n    = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({in_ready, out_valid, err_rail, err_range, busy, res, res_n}), 32'd0);
    rst_b   = 1'b1;
    b_rst_b = 1'b1;
    @(negedge clk);

    send_ok(100);
    send_ok(3329);
    send_ok(6657);
    send_ok(3328);
    send_ok(7000);
    send(100, (100 ^ 'h3FFF) ^ 8);
    send_ok(0);
    send_ok(16383);

    wait_idle();
    stall_left = 5;
    send_ok(1234);
    send_ok(4000);

    wait_idle();
    abort_pre();
    wait_idle();
    reset_mid_red();
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      s  = int'($urandom_range(0, 16383));
      sn = s ^ 'h3FFF;
      if ($urandom_range(0, 7) == 0) sn = sn ^ (1 << $urandom_range(0, 13));
      send(s, sn);
    end

    dut3_tests();

    n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
